// File: rtl/updown_counter_mod_if.sv
// Control and status bundle for the parametrised up/down counter.
// master drives controls and observes status; slave is the counter itself.
interface updown_counter_mod_if #(
  parameter int WIDTH = 4,
  parameter int EVT_W = 8
);
  logic             en;
  logic             mode;
  logic [WIDTH-1:0] step;
  logic             sat_mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             at_max;
  logic             at_min;
  logic             wrap;
  logic             sat;
  logic [EVT_W-1:0] wrap_evt;

  modport master (
    output en, mode, step, sat_mode, load, load_val,
    input  count, at_max, at_min, wrap, sat, wrap_evt
  );

  modport slave (
    input  en, mode, step, sat_mode, load, load_val,
    output count, at_max, at_min, wrap, sat, wrap_evt
  );
endinterface

// File: rtl/updown_counter_mod.sv
// Modulo up/down counter with step, load, wrap/saturate and wrap-event count; 1-cycle latency.
// No backpressure: every enabled edge updates; at_max/at_min are combinational from count.
module updown_counter_mod #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16,
  parameter int EVT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  updown_counter_mod_if.slave bus
);
  // One extra bit so count+step and count+MODULUS never overflow, even at MODULUS = 2**WIDTH.
  localparam logic [WIDTH:0] MOD_X = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] MAX_X = MOD_X - (WIDTH+1)'(1);

  logic [WIDTH-1:0] count_q;
  logic             wrap_q;
  logic             sat_q;
  logic [EVT_W-1:0] wrap_evt_q;

  logic [WIDTH:0]   cnt_x, step_x, ld_x, s_x, sum_x;
  logic [WIDTH-1:0] upd_cnt, ld_cnt;
  logic             upd_wrap, upd_sat, upd_en, ld_clip;

  always_comb begin
    cnt_x    = {1'b0, count_q};
    step_x   = {1'b0, bus.step};
    ld_x     = {1'b0, bus.load_val};
    s_x      = (step_x > MAX_X) ? MAX_X : step_x;
    ld_clip  = (ld_x > MAX_X);
    ld_cnt   = ld_clip ? WIDTH'(MAX_X) : bus.load_val;
    sum_x    = cnt_x + s_x;
    upd_en   = bus.en && (s_x != '0);
    upd_cnt  = count_q;
    upd_wrap = 1'b0;
    upd_sat  = 1'b0;
    if (!bus.mode) begin
      if (sum_x <= MAX_X) begin
        upd_cnt = WIDTH'(sum_x);
      end else if (!bus.sat_mode) begin
        upd_cnt  = WIDTH'(sum_x - MOD_X);
        upd_wrap = 1'b1;
      end else begin
        upd_cnt = WIDTH'(MAX_X);
        upd_sat = 1'b1;
      end
    end else begin
      if (s_x <= cnt_x) begin
        upd_cnt = WIDTH'(cnt_x - s_x);
      end else if (!bus.sat_mode) begin
        upd_cnt  = WIDTH'(cnt_x + MOD_X - s_x);
        upd_wrap = 1'b1;
      end else begin
        upd_cnt = '0;
        upd_sat = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      sat_q      <= 1'b0;
      wrap_evt_q <= '0;
    end else if (bus.load) begin
      count_q    <= ld_cnt;
      wrap_q     <= 1'b0;
      sat_q      <= ld_clip;
      wrap_evt_q <= '0;
    end else if (upd_en) begin
      count_q <= upd_cnt;
      wrap_q  <= upd_wrap;
      sat_q   <= upd_sat;
      if (upd_wrap && (wrap_evt_q != '1)) begin
        wrap_evt_q <= wrap_evt_q + EVT_W'(1);
      end
    end else begin
      wrap_q <= 1'b0;
      sat_q  <= 1'b0;
    end
  end

  assign bus.count    = count_q;
  assign bus.wrap     = wrap_q;
  assign bus.sat      = sat_q;
  assign bus.wrap_evt = wrap_evt_q;
  assign bus.at_max   = (count_q == WIDTH'(MAX_X));
  assign bus.at_min   = (count_q == '0);
endmodule

// File: tb/tb_updown_counter_mod.sv
// Directed-vector bench for updown_counter_mod at WIDTH=4, MODULUS=10, EVT_W=3.
module tb_updown_counter_mod;
  logic clk = 1'b0;
  logic rst;
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  updown_counter_mod_if #(.WIDTH(4), .EVT_W(3)) bus ();

  updown_counter_mod #(.WIDTH(4), .MODULUS(10), .EVT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input int c, input int w, input int s, input int e);
    chk_val({tag, ".count"}, int'(bus.count), c);
    chk_val({tag, ".wrap"}, int'(bus.wrap), w);
    chk_val({tag, ".sat"}, int'(bus.sat), s);
    chk_val({tag, ".wrap_evt"}, int'(bus.wrap_evt), e);
  endtask

  initial begin
    int exp_c, exp_e, exp_w;
    rst          = 1'b0;
    bus.en       = 1'b1;
    bus.mode     = 1'b0;
    bus.step     = 4'd1;
    bus.sat_mode = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = 4'd0;
    tick();
    tick();
    chk_state("reset", 0, 0, 0, 0);
    chk_val("reset.at_min", int'(bus.at_min), 1);
    chk_val("reset.at_max", int'(bus.at_max), 0);

    // Count up by one through the whole range and wrap.
    rst = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk_val("up.count", int'(bus.count), i);
      chk_val("up.at_max", int'(bus.at_max), (i == 9) ? 1 : 0);
    end
    tick();
    chk_state("up_wrap", 0, 1, 0, 1);
    chk_val("up_wrap.at_min", int'(bus.at_min), 1);
    tick();
    chk_state("up_after", 1, 0, 0, 1);

    // Down wrap with step 3 from 2.
    bus.load = 1'b1; bus.load_val = 4'd2;
    tick();
    chk_state("load2", 2, 0, 0, 0);
    bus.load = 1'b0; bus.mode = 1'b1; bus.step = 4'd3;
    tick();
    chk_state("dn_wrap", 9, 1, 0, 1);
    tick();
    chk_state("dn_next", 6, 0, 0, 1);

    // Saturation in both directions.
    bus.load = 1'b1; bus.load_val = 4'd8;
    tick();
    chk_state("load8", 8, 0, 0, 0);
    bus.load = 1'b0; bus.mode = 1'b0; bus.step = 4'd4; bus.sat_mode = 1'b1;
    tick();
    chk_state("sat_up", 9, 0, 1, 0);
    tick();
    chk_state("sat_up_again", 9, 0, 1, 0);
    bus.mode = 1'b1; bus.step = 4'd15;
    tick();
    chk_state("dn_clamp_step", 0, 0, 0, 0);
    tick();
    chk_state("sat_dn", 0, 0, 1, 0);

    // Load beats enable; oversize load value is clamped and flagged.
    bus.load = 1'b1; bus.load_val = 4'd13; bus.en = 1'b1;
    tick();
    chk_state("load_clamp", 9, 0, 1, 0);
    chk_val("load_clamp.at_max", int'(bus.at_max), 1);
    bus.load = 1'b0; bus.en = 1'b0;
    tick();
    chk_state("hold", 9, 0, 0, 0);

    // Zero step with enable holds and raises nothing.
    bus.en = 1'b1; bus.step = 4'd0; bus.mode = 1'b0; bus.sat_mode = 1'b0;
    tick();
    chk_state("step0", 9, 0, 0, 0);

    // Wrap-event counter saturates at 7.
    bus.load = 1'b1; bus.load_val = 4'd0;
    tick();
    chk_state("load0", 0, 0, 0, 0);
    bus.load = 1'b0; bus.step = 4'd9;
    exp_c = 0; exp_e = 0;
    for (int k = 0; k < 10; k++) begin
      exp_w = (exp_c + 9 > 9) ? 1 : 0;
      exp_c = (exp_c + 9) % 10;
      if (exp_w == 1 && exp_e < 7) exp_e++;
      tick();
      chk_state("evt_sat", exp_c, exp_w, 0, exp_e);
    end
    chk_val("evt_sat.final", int'(bus.wrap_evt), 7);

    // Reset mid-count overrides a simultaneous load.
    bus.step = 4'd5;
    tick();
    chk_state("pre_rst", 5, 0, 0, 7);
    rst = 1'b0; bus.load = 1'b1; bus.load_val = 4'd3;
    tick();
    chk_state("mid_rst", 0, 0, 0, 0);
    chk_val("mid_rst.at_min", int'(bus.at_min), 1);
    rst = 1'b1; bus.load = 1'b0; bus.step = 4'd1;
    tick();
    chk_state("resume", 1, 0, 0, 0);

    // Down saturation from a small count.
    bus.mode = 1'b1; bus.sat_mode = 1'b1; bus.step = 4'd4;
    tick();
    chk_state("sat_dn_small", 0, 0, 1, 0);
    bus.en = 1'b0;
    tick();
    chk_state("idle", 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/updown_counter_mod.md
Name: updown_counter_mod

Overview:
Parametrised up/down counter, successor to the fixed 4-bit up/down counter in the counter block family. Adds:
- arbitrary width and modulus
- programmable step
- parallel load and count enable
- runtime wrap/saturate selection
- registered wrap/saturate event pulses and a saturating wrap-event counter

Used as a general event/timer counter by datapath and test blocks. The existing counter interface/bench style extends to it directly.

Parameters:
WIDTH, 4, bit width of count, step and load_val (>=2)
MODULUS, 16, count range 0..MODULUS-1 (2 <= MODULUS <= 2**WIDTH)
EVT_W, 8, width of wrap_evt event counter

Ports:
clk  input  1  rising-edge clock, sole clock
rst  input  1  synchronous active-low reset
en  input  1  count enable; 0 = hold
mode  input  1  0 = count up, 1 = count down
step  input  WIDTH  increment/decrement amount per enabled cycle
sat_mode  input  1  0 = wrap modulo MODULUS, 1 = saturate at bounds
load  input  1  synchronous parallel load
load_val  input  WIDTH  value loaded when load=1
count  output  WIDTH  current count (registered)
at_max  output  1  count == MODULUS-1 (combinational from count)
at_min  output  1  count == 0 (combinational from count)
wrap  output  1  1-cycle registered pulse: last update wrapped
sat  output  1  1-cycle registered pulse: last update was clipped
wrap_evt  output  EVT_W  number of wraps since reset/load, saturating at all-ones

Behaviour:
- Interface is fixed: one clock; reset is synchronous and active-low.
- Reset: sampled on rising clk edge while rst=0 → count=0, wrap=0, sat=0, wrap_evt=0. Hence at_min=1, at_max=0. Reset mid-count aborts the update that cycle.
- Priority per edge: rst=0 > load=1 > en=1 > hold.
- Load: count <= min(load_val, MODULUS-1); wrap=0; sat=1 only if load_val was clamped; wrap_evt <= 0. Load overrides en in the same cycle.
- Effective step: s = min(step, MODULUS-1). When en=1 and s=0: count holds, no pulses.
- Up (mode=0), s>0:
  - if count+s <= MODULUS-1: count <= count+s
  - else if sat_mode=0: count <= count+s-MODULUS; wrap=1
  - else: count <= MODULUS-1; sat=1 (sat=1 even if count was already MODULUS-1)
- Down (mode=1), s>0:
  - if s <= count: count <= count-s
  - else if sat_mode=0: count <= count+MODULUS-s; wrap=1
  - else: count <= 0; sat=1
- Arithmetic uses WIDTH+1 bits internally; no intermediate overflow for any legal MODULUS (including MODULUS = 2**WIDTH).
- wrap/sat: registered alongside count; high exactly one cycle after the causing edge; cleared on every other edge. wrap and sat are never both 1.
- wrap_evt: +1 on each wrap; holds at 2**EVT_W-1.
- Hold (en=0, load=0): count and wrap_evt hold; wrap and sat return to 0.
- Latency: count, wrap, sat reflect the edge at which inputs were sampled; at_max/at_min follow count combinationally.
- mode, sat_mode and step may change every cycle; only values sampled at the active edge matter.

Test Plan:
(all with WIDTH=4, MODULUS=10, EVT_W=3)
- Reset: hold rst=0 for 2 edges with en=1 → count=0, at_min=1, wrap=0, sat=0, wrap_evt=0. Release rst, en=1, mode=0, step=1 → count 1,2,…,9 (at_max=1 at 9), then 0 with wrap=1 for one cycle, wrap_evt=1.
- Down wrap with step: load_val=2, then en=1, mode=1, step=3, sat_mode=0 → count=9, wrap=1. Next edge → 6, wrap=0.
- Saturation: load_val=8, up, step=4, sat_mode=1 → count=9, sat=1. Next edge → 9, sat=1 again. Switch mode=1, step=15 (clamped to 9) → 0; next edge → 0, sat=1.
- Load priority and clamp: load=1, load_val=13, en=1 in the same cycle → count=9, sat=1, wrap_evt=0. Hold en=0 → count stays 9, sat=0.
- wrap_evt saturation: up, step=9, sat_mode=0 for 10 edges → wraps on 9 of them (0→9 does not wrap), wrap_evt stops at 7.
- Mid-operation reset: counting at count=5, assert rst=0 for one edge together with load=1 → count=0, wrap_evt=0, pulses low; counting resumes from 0 on the next enabled edge.
